dino_motion: RTL and testbench
==============================

# dino_motion

Per-frame motion controller for the dino sprite. Sits directly upstream of the VGA controller and drives its `dino_x`/`dino_y` inputs. It converts the `up`/`down` player buttons into run, jump and duck motion, and advances the physics once per video frame, on the controller's `screenEnd` pulse. It runs entirely in the 100 MHz system clock domain.

## Interface
- `GROUND`, 335: ground line y; the sprite bottom rests here.
- `DINO_H`, 60: sprite height in pixels.
- `DINO_X`, 50: fixed left x of the sprite.
- `JUMP_V`, 12: launch velocity, in pixels/frame.
- `GRAVITY`, 1: velocity decrement per frame.
- `DUCK_DROP`, 20: downward y offset applied while ducking.

- `clk`, in, 1: 100 MHz system clock. Everything runs in this single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `frame_tick`, in, 1: `screenEnd` from the VGA controller. It is a level that stays high for several `clk` cycles.
- `up`, in, 1: jump button. Already debounced and synchronous.
- `down`, in, 1: duck button. Already debounced and synchronous.
- `freeze`, in, 1: game-over hold. While high, frame updates are ignored.
- `dino_x`, out, 32: sprite left x. Constant `DINO_X`.
- `dino_y`, out, 32: sprite top y.
- `airborne`, out, 1: high when the state is AIR.
- `ducking`, out, 1: high when the state is DUCK.
- `jump_count`, out, 8: number of launches since reset. Saturates at 255.

## Operation
- **Frame strobe.** `frame_tick_d` registers `frame_tick`. The update strobe is `frame_tick & ~frame_tick_d & ~freeze`. Exactly one update occurs per high period of `frame_tick`.
- **Internal registers.**
  - `height`: 9-bit unsigned, pixels above ground.
  - `vel`: 8-bit signed.
  - `state`: one of RUN, DUCK, AIR.
- **Sampling.** `up` and `down` are sampled only on the update cycle.
- **RUN**
  - `up` → AIR. Set `height = JUMP_V`, `vel = JUMP_V - GRAVITY`, and increment `jump_count`.
  - Otherwise `down` → DUCK.
  - Otherwise stay in RUN.
- **DUCK**
  - `up` → AIR, as a launch from RUN. `up` has priority over `down`.
  - `down` low → RUN.
  - `down` high → stay in DUCK.
- **AIR**
  - Compute `sum = height + vel` in 10-bit signed.
  - If `sum <= 0`: set `height = 0`, `vel = 0`, and go to RUN regardless of buttons. A re-jump needs a later update.
  - Otherwise: set `height = sum`, `vel = vel - GRAVITY`.
  - Buttons are ignored while in AIR.
- **Outputs**
  - `dino_y = GROUND - DINO_H - height + (state==DUCK ? DUCK_DROP : 0)`, zero-extended to 32 bits.
  - `airborne = (state==AIR)`; `ducking = (state==DUCK)`.
- **Parameter legality.** Peak height is at most `GROUND - DINO_H`. For the defaults, the peak is 78 against a limit of 275. `vel` never exceeds ±127.
- **freeze.** Holds all state and outputs. `frame_tick_d` still tracks `frame_tick`, so releasing `freeze` during a high tick does not create an update.

## Timing
- **Reset values.**
  - state RUN, `height` 0, `vel` 0, `jump_count` 0.
  - `frame_tick_d` = 1, so a tick already high at reset release is not an edge.
  - Outputs: `dino_x` = 50, `dino_y` = 275, `airborne` 0, `ducking` 0.
- **Update latency.** The update happens on the first `clk` edge at which `frame_tick=1` and `frame_tick_d=0`. All outputs are registered and show the new values immediately after that edge (1 cycle).
- **Reset mid-jump.** Reset during AIR returns to the reset values on the next edge and takes priority over a coincident strobe.
- **Default jump profile (from RUN, `up` on update 1).**
  - Heights per update: 12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78, 77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, then landing (0) on update 25.
  - `airborne` is high for 24 frames.
- **Combinational path.** `dino_y` is derived from registers only. There is no combinational path from any input to any output.

## Test plan
- **Reset:** assert `reset` for 3 cycles with `frame_tick` high, then release → `dino_y`=275, `dino_x`=50, RUN. The first strobe comes only after `frame_tick` falls and rises again.
- **Full jump:** `up`=1 for one frame, 30 frame pulses, each 4 `clk` wide → `dino_y` sequence 263, 252, …, 197 (peak, twice), …, 263, 275. `airborne` is high for exactly 24 updates; `jump_count`=1.
- **Duck:** `down` held for 3 frames → `dino_y`=295 and `ducking`=1 after the first update. Release `down` → 275 at the next update. `up`+`down` together in DUCK → AIR with `dino_y`=263.
- **Buttons in AIR:** toggle `up`/`down` throughout a jump → profile identical to the full-jump case, `jump_count` increments once. `up` held at the landing update → RUN, with the relaunch on the following update.
- **Freeze:** assert `freeze` at height 50 for 5 frames → all outputs constant. Deassert while `frame_tick` is high → no update until the next rising edge, then height 57.
- **Reset mid-air:** assert `reset` at height 72 on the same cycle as a strobe edge → RUN, `dino_y`=275, `jump_count`=0.

Source files
------------

// File: rtl/dino_motion_if.sv
// rtl/dino_motion_if.sv - button/frame inputs and sprite position outputs of the dino motion controller
interface dino_motion_if;
    logic        frame_tick;
    logic        up;
    logic        down;
    logic        freeze;
    logic [31:0] dino_x;
    logic [31:0] dino_y;
    logic        airborne;
    logic        ducking;
    logic [7:0]  jump_count;

    modport master (
        input  frame_tick, up, down, freeze,
        output dino_x, dino_y, airborne, ducking, jump_count
    );

    modport slave (
        output frame_tick, up, down, freeze,
        input  dino_x, dino_y, airborne, ducking, jump_count
    );
endinterface

// File: rtl/dino_motion.sv
// rtl/dino_motion.sv - per-frame run/jump/duck physics for the dino sprite
module dino_motion #(
    parameter int GROUND    = 335,
    parameter int DINO_H    = 60,
    parameter int DINO_X    = 50,
    parameter int JUMP_V    = 12,
    parameter int GRAVITY   = 1,
    parameter int DUCK_DROP = 20
) (
    input  logic          clk,
    input  logic          reset,
    dino_motion_if.master bus
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DUCK = 2'd1,
        AIR  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [8:0]        height, height_n;
    logic signed [7:0] vel, vel_n;
    logic [7:0]        jump_count, jump_count_n;
    logic              frame_tick_d;
    logic              strobe;
    logic signed [9:0] sum;

    // frame_tick_d resets high so a tick already high at reset release is not an edge
    assign strobe = bus.frame_tick & ~frame_tick_d & ~bus.freeze;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            height       <= 9'd0;
            vel          <= 8'sd0;
            jump_count   <= 8'd0;
            frame_tick_d <= 1'b1;
        end else begin
            state        <= state_n;
            height       <= height_n;
            vel          <= vel_n;
            jump_count   <= jump_count_n;
            frame_tick_d <= bus.frame_tick;
        end
    end

    always_comb begin
        state_n      = state;
        height_n     = height;
        vel_n        = vel;
        jump_count_n = jump_count;
        sum          = $signed({1'b0, height}) + $signed({{2{vel[7]}}, vel});
        if (strobe) begin
            case (state)
                RUN, DUCK: begin
                    if (bus.up) begin
                        state_n  = AIR;
                        height_n = 9'(JUMP_V);
                        vel_n    = 8'(JUMP_V - GRAVITY);
                        if (jump_count != 8'hFF)
                            jump_count_n = jump_count + 8'd1;
                    end else if (bus.down) begin
                        state_n = DUCK;
                    end else begin
                        state_n = RUN;
                    end
                end
                AIR: begin
                    // landing ignores buttons; a relaunch needs the following update
                    if (sum <= 10'sd0) begin
                        state_n  = RUN;
                        height_n = 9'd0;
                        vel_n    = 8'sd0;
                    end else begin
                        height_n = sum[8:0];
                        vel_n    = vel - 8'(GRAVITY);
                    end
                end
                default: begin
                    state_n  = RUN;
                    height_n = 9'd0;
                    vel_n    = 8'sd0;
                end
            endcase
        end
    end

    assign bus.dino_x     = 32'(DINO_X);
    assign bus.dino_y     = 32'(GROUND - DINO_H + ((state == DUCK) ? DUCK_DROP : 0)) - 32'(height);
    assign bus.airborne   = (state == AIR);
    assign bus.ducking    = (state == DUCK);
    assign bus.jump_count = jump_count;

endmodule

// File: tb/tb_dino_motion.sv
// tb/tb_dino_motion.sv - directed bench with closed-form jump model for dino_motion
module tb_dino_motion;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    bit   check_en = 1'b0;

    dino_motion_if bus();

    dino_motion dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // model: airborne frame index k gives height k*V - G*k*(k-1)/2
    int m_k = 0;
    bit m_duck = 1'b0;
    int m_jumps = 0;
    bit m_prev = 1'b1;

    function automatic int hgt(input int k);
        if (k <= 0) return 0;
        return k * 12 - (k * (k - 1)) / 2;
    endfunction

    function automatic int model_y();
        return 335 - 60 - hgt(m_k) + (m_duck ? 20 : 0);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_k     <= 0;
            m_duck  <= 1'b0;
            m_jumps <= 0;
            m_prev  <= 1'b1;
        end else begin
            m_prev <= bus.frame_tick;
            if (bus.frame_tick && !m_prev && !bus.freeze) begin
                if (m_k > 0) begin
                    if (hgt(m_k + 1) <= 0) m_k <= 0;
                    else m_k <= m_k + 1;
                end else if (bus.up) begin
                    m_k     <= 1;
                    m_duck  <= 1'b0;
                    m_jumps <= (m_jumps < 255) ? m_jumps + 1 : 255;
                end else begin
                    m_duck <= bus.down;
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("dino_y", bus.dino_y, model_y());
            chk("dino_x", bus.dino_x, 50);
            chk("airborne", bus.airborne, (m_k > 0) ? 1 : 0);
            chk("ducking", bus.ducking, m_duck ? 1 : 0);
            chk("jump_count", bus.jump_count, m_jumps);
        end
    end

    task automatic tick(input int hi = 4, input int lo = 4);
        bus.frame_tick = 1'b1;
        repeat (hi) @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    int ys[1:30];
    int air_cnt;

    initial begin
        reset          = 1'b1;
        bus.frame_tick = 1'b1;
        bus.up         = 1'b0;
        bus.down       = 1'b0;
        bus.freeze     = 1'b0;

        // reset with tick high; no strobe until tick falls and rises again
        @(negedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        bus.up = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_y", bus.dino_y, 275);
        chk("rst_x", bus.dino_x, 50);
        chk("rst_no_launch", bus.jump_count, 0);
        chk("rst_air", bus.airborne, 0);
        bus.frame_tick = 1'b0;
        bus.up = 1'b0;
        repeat (2) @(negedge clk);
        tick();
        chk("idle_y", bus.dino_y, 275);

        // full jump
        air_cnt = 0;
        for (int u = 1; u <= 30; u++) begin
            bus.up = (u == 1);
            tick();
            ys[u] = int'(bus.dino_y);
            air_cnt += int'(bus.airborne);
        end
        chk("jump_u1", ys[1], 263);
        chk("jump_u2", ys[2], 252);
        chk("jump_peak12", ys[12], 197);
        chk("jump_peak13", ys[13], 197);
        chk("jump_u24", ys[24], 263);
        chk("jump_land", ys[25], 275);
        chk("jump_after", ys[30], 275);
        chk("jump_air_cnt", air_cnt, 24);
        chk("jump_count1", bus.jump_count, 1);

        // duck
        bus.down = 1'b1;
        tick();
        chk("duck_y", bus.dino_y, 295);
        chk("duck_flag", bus.ducking, 1);
        tick();
        tick();
        bus.down = 1'b0;
        tick();
        chk("unduck_y", bus.dino_y, 275);
        bus.down = 1'b1;
        tick();
        bus.up = 1'b1;
        tick();
        chk("duck_launch_y", bus.dino_y, 263);
        chk("duck_launch_air", bus.airborne, 1);
        bus.up = 1'b0;
        bus.down = 1'b0;
        repeat (24) tick();
        chk("duck_jump_land", bus.dino_y, 275);

        // buttons ignored while airborne; up held at landing relaunches one update later
        bus.up = 1'b1;
        tick();
        for (int u = 2; u <= 24; u++) begin
            bus.up   = 1'($urandom_range(0, 1));
            bus.down = 1'($urandom_range(0, 1));
            tick();
            if (u == 12) chk("toggle_peak", bus.dino_y, 197);
        end
        chk("toggle_u24", bus.dino_y, 263);
        chk("toggle_jc", bus.jump_count, 3);
        bus.up = 1'b1;
        bus.down = 1'b0;
        tick();
        chk("land_held_y", bus.dino_y, 275);
        chk("land_held_air", bus.airborne, 0);
        tick();
        chk("relaunch_y", bus.dino_y, 263);
        chk("relaunch_jc", bus.jump_count, 4);
        bus.up = 1'b0;
        repeat (24) tick();
        chk("relaunch_land", bus.dino_y, 275);

        // freeze at height 50
        bus.up = 1'b1;
        tick();
        bus.up = 1'b0;
        repeat (4) tick();
        chk("pre_freeze_y", bus.dino_y, 225);
        bus.freeze = 1'b1;
        repeat (5) tick();
        chk("frozen_y", bus.dino_y, 225);
        bus.frame_tick = 1'b1;
        repeat (2) @(negedge clk);
        bus.freeze = 1'b0;
        repeat (2) @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        chk("unfreeze_hold_y", bus.dino_y, 225);
        tick();
        chk("unfreeze_next_y", bus.dino_y, 218);

        // reset mid-air at height 72, coincident with a tick edge
        repeat (3) tick();
        chk("pre_reset_y", bus.dino_y, 203);
        bus.frame_tick = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midair_rst_y", bus.dino_y, 275);
        chk("midair_rst_jc", bus.jump_count, 0);
        chk("midair_rst_air", bus.airborne, 0);
        repeat (3) @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_y", bus.dino_y, 275);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
